// File: rtl/ctrl_types_pkg.sv
// Shared control-path types for the cache controller and its request arbiter.
//   operation_e : operation code sent to the cache controller (NOOP = no request)
//   arb_state_e : op_arbiter FSM states
//   arb_rsp_t   : registered response payload returned to a requester
package ctrl_types_pkg;

  typedef enum logic [1:0] {
    NOOP   = 2'd0,
    READ   = 2'd1,
    UPSERT = 2'd2,
    DELETE = 2'd3
  } operation_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic hit;
    logic err;
  } arb_rsp_t;

  // A requester only competes when it is valid and asks for a real operation.
  function automatic logic op_eligible(input logic valid, input operation_e op);
    return valid && (op != NOOP);
  endfunction

endpackage

// File: rtl/op_arbiter_if.sv
// Requester/controller bus of op_arbiter.
//   Requester side : req_valid_in, req_op_in -> req_ready_out, rsp_valid_out,
//                    rsp_hit_out, rsp_err_out, sel_out, busy_out
//   Controller side: ctrl_operation_out -> ctrl_busy_in, ctrl_busy_valid_in,
//                    ctrl_hit_in, ctrl_hit_valid_in, ctrl_operation_valid_in
// slave = arbiter view, master = environment (requesters + controller) view.
interface op_arbiter_if #(
  parameter int unsigned N_REQ = 2
);

  logic [N_REQ-1:0]          req_valid_in;
  ctrl_types_pkg::operation_e req_op_in [N_REQ];
  logic [N_REQ-1:0]          req_ready_out;
  logic [N_REQ-1:0]          rsp_valid_out;
  logic                      rsp_hit_out;
  logic                      rsp_err_out;
  logic [N_REQ-1:0]          sel_out;
  logic                      busy_out;
  ctrl_types_pkg::operation_e ctrl_operation_out;
  logic                      ctrl_busy_in;
  logic                      ctrl_busy_valid_in;
  logic                      ctrl_hit_in;
  logic                      ctrl_hit_valid_in;
  logic                      ctrl_operation_valid_in;

  modport slave (
    input  req_valid_in, req_op_in,
    input  ctrl_busy_in, ctrl_busy_valid_in, ctrl_hit_in, ctrl_hit_valid_in,
           ctrl_operation_valid_in,
    output req_ready_out, rsp_valid_out, rsp_hit_out, rsp_err_out, sel_out,
           busy_out, ctrl_operation_out
  );

  modport master (
    output req_valid_in, req_op_in,
    output ctrl_busy_in, ctrl_busy_valid_in, ctrl_hit_in, ctrl_hit_valid_in,
           ctrl_operation_valid_in,
    input  req_ready_out, rsp_valid_out, rsp_hit_out, rsp_err_out, sel_out,
           busy_out, ctrl_operation_out
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of eligible_i searching
// upward from rr_ptr_i and wrapping.
//   eligible_i : request vector
//   rr_ptr_i   : highest-priority index (must be < N)
//   grant_c    : one-hot winner (zero when none)
//   index_c    : winner index (zero when none)
//   any_c      : at least one eligible request
module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [IW-1:0] rr_ptr_i,
  output logic [N-1:0]  grant_c,
  output logic [IW-1:0] index_c,
  output logic          any_c
);

  logic [IW:0]   cand;
  logic [IW-1:0] cand_idx;

  // Walk N candidates starting at the pointer; the first eligible one wins.
  always_comb begin
    grant_c  = '0;
    index_c  = '0;
    any_c    = 1'b0;
    cand     = '0;
    cand_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (IW+1)'(rr_ptr_i) + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      cand_idx = IW'(cand);
      if (!any_c && eligible_i[cand_idx]) begin
        any_c             = 1'b1;
        grant_c[cand_idx] = 1'b1;
        index_c           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/op_arbiter.sv
// Round-robin arbiter giving N_REQ requesters exclusive, one-at-a-time use of
// the cache controller, with a watchdog that forces an error response.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : op_arbiter_if slave (requester handshakes, owner select,
//                busy flag, controller operation and status)
module op_arbiter
  import ctrl_types_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  op_arbiter_if.slave bus
);

  localparam int unsigned   IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned   CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    winner_q, winner_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] ready_q, ready_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  arb_rsp_t         rsp_q, rsp_d;
  logic             busy_q, busy_d;
  operation_e       ctrl_op_q, ctrl_op_d;

  logic [N_REQ-1:0] elig_c;
  logic [N_REQ-1:0] grant_c;
  logic [IW-1:0]    index_c;
  logic             any_c;
  logic             done_c;
  logic [CW-1:0]    cnt_inc_c;

  // Eligibility filter: NOOP requests never compete.
  always_comb begin
    elig_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      elig_c[i] = op_eligible(bus.req_valid_in[i], bus.req_op_in[i]);
    end
  end

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .eligible_i (elig_c),
    .rr_ptr_i   (rr_ptr_q),
    .grant_c    (grant_c),
    .index_c    (index_c),
    .any_c      (any_c)
  );

  // Next state and next registered outputs. Outputs are computed one cycle
  // early so that they are valid exactly during the state they belong to.
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    ready_d     = '0;
    rsp_valid_d = '0;
    rsp_d       = '0;
    ctrl_op_d   = NOOP;
    done_c      = bus.ctrl_busy_valid_in && !bus.ctrl_busy_in;
    // Saturating increment; the timeout fires when it lands on TIMEOUT-1.
    cnt_inc_c   = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CW'(1);

    case (state_q)
      ARB_IDLE: begin
        if (any_c) begin
          winner_d  = index_c;
          sel_d     = grant_c;
          ready_d   = grant_c;
          ctrl_op_d = bus.req_op_in[index_c];
          state_d   = ARB_ISSUE;
        end
      end

      ARB_ISSUE: begin
        cnt_d   = '0;
        state_d = ARB_WAIT;
      end

      ARB_WAIT: begin
        if (done_c) begin
          rsp_d.err   = !bus.ctrl_operation_valid_in;
          rsp_d.hit   = bus.ctrl_hit_in && bus.ctrl_hit_valid_in &&
                        bus.ctrl_operation_valid_in;
          rsp_valid_d = sel_q;
          state_d     = ARB_RESP;
        end else begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == CNT_LAST) begin
            rsp_d.err   = 1'b1;
            rsp_d.hit   = 1'b0;
            rsp_valid_d = sel_q;
            state_d     = ARB_RESP;
          end
        end
      end

      ARB_RESP: begin
        rr_ptr_d = (winner_q == IDX_LAST) ? '0 : winner_q + IW'(1);
        sel_d    = '0;
        state_d  = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
        sel_d   = '0;
      end
    endcase

    busy_d = (state_d != ARB_IDLE);
  end

  // All arbiter state; reset aborts any transaction without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      winner_q    <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      ready_q     <= '0;
      rsp_valid_q <= '0;
      rsp_q       <= '0;
      busy_q      <= 1'b0;
      ctrl_op_q   <= NOOP;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      busy_q      <= busy_d;
      ctrl_op_q   <= ctrl_op_d;
    end
  end

  assign bus.req_ready_out      = ready_q;
  assign bus.rsp_valid_out      = rsp_valid_q;
  assign bus.rsp_hit_out        = rsp_q.hit;
  assign bus.rsp_err_out        = rsp_q.err;
  assign bus.sel_out            = sel_q;
  assign bus.busy_out           = busy_q;
  assign bus.ctrl_operation_out = ctrl_op_q;

endmodule

// File: tb/tb_op_arbiter.sv
// Scoreboard bench for op_arbiter: the driver pushes expected grants and
// responses from a transaction-level model; a negedge monitor pops and compares.
module tb_op_arbiter;
  import ctrl_types_pkg::*;

  localparam int unsigned N_REQ   = 2;
  localparam int unsigned TIMEOUT = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  op_arbiter_if #(.N_REQ(N_REQ)) bus ();

  op_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { int req; operation_e op; } issue_t;
  typedef struct { int req; logic hit; logic err; int gap; } rsp_t;

  issue_t     exp_issue[$];
  rsp_t       exp_rsp[$];
  issue_t     mon_i;
  rsp_t       mon_r;
  int         n_checks  = 0;
  int         n_fail    = 0;
  int         cyc       = 0;
  int         ready_cyc = 0;
  bit         pend_v  [N_REQ];
  operation_e pend_op [N_REQ];
  int         model_rr  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event seen, none expected (cycle %0d)", name, cyc);
  endtask

  // Monitor: compare every presented grant/response against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req_ready_out != '0) begin
        if (exp_issue.size() == 0) fail_event("unexpected_ready");
        else begin
          mon_i = exp_issue.pop_front();
          check("ready_vec", 32'(bus.req_ready_out), 32'(1) << mon_i.req);
          check("issue_op", 32'(bus.ctrl_operation_out), 32'(mon_i.op));
          check("issue_sel", 32'(bus.sel_out), 32'(1) << mon_i.req);
          ready_cyc = cyc;
        end
      end else begin
        check("op_noop_outside_issue", 32'(bus.ctrl_operation_out), 32'(NOOP));
      end
      if (bus.rsp_valid_out != '0) begin
        if (exp_rsp.size() == 0) fail_event("unexpected_rsp");
        else begin
          mon_r = exp_rsp.pop_front();
          check("rsp_vec", 32'(bus.rsp_valid_out), 32'(1) << mon_r.req);
          check("rsp_hit", 32'(bus.rsp_hit_out), 32'(mon_r.hit));
          check("rsp_err", 32'(bus.rsp_err_out), 32'(mon_r.err));
          check("rsp_latency", 32'(cyc - ready_cyc), 32'(mon_r.gap));
          check("rsp_sel", 32'(bus.sel_out), 32'(1) << mon_r.req);
        end
      end else begin
        check("hit_unqualified", 32'(bus.rsp_hit_out), 32'd0);
        check("err_unqualified", 32'(bus.rsp_err_out), 32'd0);
      end
      check("busy_vs_sel", 32'(bus.busy_out), 32'(bus.sel_out != '0));
      check("sel_onehot0", 32'($countones(bus.sel_out) <= 1), 32'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_valid_in[i] = pend_v[i];
      bus.req_op_in[i]    = pend_op[i];
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N_REQ; i++) begin
      pend_v[i]  = 1'b0;
      pend_op[i] = NOOP;
    end
    drive_reqs();
  endtask

  task automatic drive_ctrl(input logic busy, input logic bv, input logic hit,
                            input logic hv, input logic ov);
    bus.ctrl_busy_in            = busy;
    bus.ctrl_busy_valid_in      = bv;
    bus.ctrl_hit_in             = hit;
    bus.ctrl_hit_valid_in       = hv;
    bus.ctrl_operation_valid_in = ov;
  endtask

  // Arbitrary status, including completion-looking values, for cycles in
  // which the arbiter must not be listening.
  task automatic drive_noise();
    drive_ctrl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Status that is never a completion.
  task automatic drive_not_done();
    logic bv;
    bv = 1'($urandom);
    drive_ctrl(bv ? 1'b1 : 1'($urandom), bv, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Reference pick: first eligible requester at or after the rr pointer.
  function automatic int model_pick();
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = (model_rr + k) % N_REQ;
      if (pend_v[j] && pend_op[j] != NOOP) return j;
    end
    return -1;
  endfunction

  // One full transaction, entered #1 after the edge into an IDLE cycle with
  // requests already driven. d = WAIT cycle of completion (> TIMEOUT-1: never).
  task automatic run_txn(input int d, input bit ov, input bit hit, input bit hv,
                         input bit keep, input operation_e new_op);
    int   w;
    int   d_eff;
    int   n;
    rsp_t r;
    w = model_pick();
    if (w < 0) return;
    d_eff = (d < int'(TIMEOUT) - 1) ? d : int'(TIMEOUT) - 1;
    r.req = w;
    r.gap = d_eff + 1;
    if (d <= int'(TIMEOUT) - 1) begin
      r.hit = hit & hv & ov;
      r.err = !ov;
    end else begin
      r.hit = 1'b0;
      r.err = 1'b1;
    end
    exp_issue.push_back('{req: w, op: pend_op[w]});
    exp_rsp.push_back(r);
    model_rr = (w + 1) % N_REQ;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.req_ready_out == '0 && n < 10);
    check("grant_to_ready_cycles", 32'(n), 32'd1);
    // Winner's request is consumed; it may immediately post a different one.
    pend_v[w]  = keep;
    pend_op[w] = keep ? new_op : NOOP;
    drive_reqs();
    drive_noise();
    for (int k = 1; k <= d_eff; k++) begin
      step();
      if (k == d) drive_ctrl(1'b0, 1'b1, hit, hv, ov);
      else drive_not_done();
    end
    step();
    drive_noise();
    step();
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    clear_reqs();
    exp_issue.delete();
    exp_rsp.delete();
    model_rr = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    clear_reqs();
    drive_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    check("rst_ready", 32'(bus.req_ready_out), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid_out), 32'd0);
    check("rst_sel", 32'(bus.sel_out), 32'd0);
    check("rst_busy", 32'(bus.busy_out), 32'd0);
    check("rst_op", 32'(bus.ctrl_operation_out), 32'(NOOP));
    check("rst_hit", 32'(bus.rsp_hit_out), 32'd0);
    check("rst_err", 32'(bus.rsp_err_out), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    // Single READ, completion on WAIT cycle 2 with a hit
    pend_v[0] = 1'b1; pend_op[0] = READ; drive_reqs();
    run_txn(2, 1'b1, 1'b1, 1'b1, 1'b0, NOOP);

    // Contention straight after reset: req0 first, then req1, pointer back to 0
    pulse_reset();
    pend_v[0] = 1'b1; pend_op[0] = UPSERT;
    pend_v[1] = 1'b1; pend_op[1] = DELETE;
    drive_reqs();
    run_txn(1, 1'b1, 1'b0, 1'b0, 1'b0, NOOP);
    run_txn(3, 1'b1, 1'b1, 1'b0, 1'b0, NOOP);
    pend_v[0] = 1'b1; pend_op[0] = READ;
    pend_v[1] = 1'b1; pend_op[1] = READ;
    drive_reqs();
    run_txn(1, 1'b1, 1'b1, 1'b1, 1'b0, NOOP);
    run_txn(1, 1'b1, 1'b0, 1'b1, 1'b0, NOOP);

    // Controller error: completion with operation_valid low masks the hit
    pend_v[1] = 1'b1; pend_op[1] = UPSERT; drive_reqs();
    run_txn(1, 1'b0, 1'b1, 1'b1, 1'b0, NOOP);

    // Timeout: no completion ever; also the completion-vs-timeout tie
    pend_v[0] = 1'b1; pend_op[0] = DELETE; drive_reqs();
    run_txn(100, 1'b1, 1'b1, 1'b1, 1'b0, NOOP);
    pend_v[1] = 1'b1; pend_op[1] = READ; drive_reqs();
    run_txn(int'(TIMEOUT) - 1, 1'b1, 1'b1, 1'b1, 1'b0, NOOP);

    // Reset in the middle of WAIT: outputs drop at once, no response follows
    pend_v[0] = 1'b1; pend_op[0] = READ; drive_reqs();
    exp_issue.push_back('{req: model_pick(), op: READ});
    begin
      int n;
      n = 0;
      do begin
        step();
        n++;
      end while (bus.req_ready_out == '0 && n < 10);
      check("midrst_grant_to_ready", 32'(n), 32'd1);
    end
    clear_reqs();
    repeat (3) begin
      step();
      drive_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(bus.req_ready_out), 32'd0);
    check("midrst_rsp_valid", 32'(bus.rsp_valid_out), 32'd0);
    check("midrst_sel", 32'(bus.sel_out), 32'd0);
    check("midrst_busy", 32'(bus.busy_out), 32'd0);
    check("midrst_op", 32'(bus.ctrl_operation_out), 32'(NOOP));
    check("midrst_err", 32'(bus.rsp_err_out), 32'd0);
    exp_rsp.delete();
    model_rr = 0;
    drive_ctrl(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (12) step();
    pend_v[1] = 1'b1; pend_op[1] = DELETE; drive_reqs();
    run_txn(3, 1'b1, 1'b1, 1'b1, 1'b0, NOOP);

    // NOOP requests never win
    pend_v[0] = 1'b1; pend_op[0] = NOOP;
    pend_v[1] = 1'b1; pend_op[1] = NOOP;
    drive_reqs();
    repeat (20) begin
      step();
      check("noop_no_ready", 32'(bus.req_ready_out), 32'd0);
      check("noop_not_busy", 32'(bus.busy_out), 32'd0);
    end
    clear_reqs();

    // Randomized traffic; losers stay pending so fairness is exercised
    for (int it = 0; it < 120; it++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if ((!pend_v[i] || pend_op[i] == NOOP) && $urandom_range(0, 1) == 1) begin
          pend_v[i]  = 1'b1;
          pend_op[i] = operation_e'(2'($urandom_range(0, 3)));
        end
      end
      drive_reqs();
      if (model_pick() < 0) begin
        step();
        check("rand_idle_not_busy", 32'(bus.busy_out), 32'd0);
      end else begin
        run_txn(int'($urandom_range(1, 10)), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), operation_e'(2'($urandom_range(0, 3))));
      end
    end

    clear_reqs();
    repeat (4) step();
    check("issue_queue_drained", 32'(exp_issue.size()), 32'd0);
    check("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
